// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch/jump flushes,
// data-memory freezes, plus a saturating count of cycles with the PC held.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             Branch_Taken,
    input  logic             JtoPC,
    input  logic             Mem_Busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic [CNT_W-1:0] Stall_Count
);

    // RUN: normal issue | MEM_WAIT: frozen on dmem | LD_STALL: load-use bubbles | BR_FLUSH: post-branch flush
    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_LD_STALL, S_BR_FLUSH} state_t;

    localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_INIT = 3'(BR_PENALTY - 1);

    state_t           r_state, w_next_state;
    logic [2:0]       r_cnt, w_next_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hazard_lu;

    assign w_hazard_lu = EX_MemRead && (EX_Rt != 5'd0) &&
                         ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_comb begin
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Write  = 1'b1;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (RST) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            w_next_state = S_RUN;
            w_next_cnt   = 3'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (Mem_Busy) begin
                        PC_Write     = 1'b0;
                        IFID_Write   = 1'b0;
                        EXMEM_Write  = 1'b0;
                        w_next_state = S_MEM_WAIT;
                    end else if (Branch_Taken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                        if (BR_PENALTY > 1) begin
                            w_next_state = S_BR_FLUSH;
                            w_next_cnt   = BR_INIT;
                        end
                    end else if (w_hazard_lu) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_next_state = S_LD_STALL;
                            w_next_cnt   = LD_INIT;
                        end
                    end else if (JtoPC) begin
                        IFID_Flush = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (Mem_Busy) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        EXMEM_Write = 1'b0;
                    end else begin
                        w_next_state = S_RUN;
                    end
                end
                S_LD_STALL: begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    if (Mem_Busy) begin
                        EXMEM_Write = 1'b0;
                    end else begin
                        IDEX_Bubble = 1'b1;
                        w_next_cnt  = r_cnt - 3'd1;
                        if (r_cnt <= 3'd1) w_next_state = S_RUN;
                    end
                end
                S_BR_FLUSH: begin
                    IFID_Flush = 1'b1;
                    if (Mem_Busy) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        EXMEM_Write = 1'b0;
                    end else begin
                        w_next_cnt = r_cnt - 3'd1;
                        if (r_cnt <= 3'd1) w_next_state = S_RUN;
                    end
                end
                default: w_next_state = S_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_RUN;
            r_cnt       <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (!PC_Write && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign Stall_Count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Three differently-parameterised controllers on shared inputs, each checked every cycle
// against a remaining-cycles model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_usesrt, ex_memread, br, jp, busy;
    logic [2:0] pc_w, ifid_w, ifid_f, idex_b, exmem_w;
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    int errors = 0;
    int checks = 0;

    int LL[3]   = '{1, 3, 2};
    int BRP[3]  = '{1, 2, 3};
    int MAXC[3] = '{65535, 65535, 15};

    int m_ld[3], m_br[3], m_sc[3];
    bit m_mw[3];

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .BR_PENALTY(1), .CNT_W(16)) u0 (
        .CLK(CLK), .RST(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_usesrt),
        .EX_MemRead(ex_memread), .EX_Rt(ex_rt), .Branch_Taken(br), .JtoPC(jp), .Mem_Busy(busy),
        .PC_Write(pc_w[0]), .IFID_Write(ifid_w[0]), .IFID_Flush(ifid_f[0]),
        .IDEX_Bubble(idex_b[0]), .EXMEM_Write(exmem_w[0]), .Stall_Count(sc0));

    pipe_hazard_ctrl #(.LOAD_LAT(3), .BR_PENALTY(2), .CNT_W(16)) u1 (
        .CLK(CLK), .RST(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_usesrt),
        .EX_MemRead(ex_memread), .EX_Rt(ex_rt), .Branch_Taken(br), .JtoPC(jp), .Mem_Busy(busy),
        .PC_Write(pc_w[1]), .IFID_Write(ifid_w[1]), .IFID_Flush(ifid_f[1]),
        .IDEX_Bubble(idex_b[1]), .EXMEM_Write(exmem_w[1]), .Stall_Count(sc1));

    pipe_hazard_ctrl #(.LOAD_LAT(2), .BR_PENALTY(3), .CNT_W(4)) u2 (
        .CLK(CLK), .RST(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_usesrt),
        .EX_MemRead(ex_memread), .EX_Rt(ex_rt), .Branch_Taken(br), .JtoPC(jp), .Mem_Busy(busy),
        .PC_Write(pc_w[2]), .IFID_Write(ifid_w[2]), .IFID_Flush(ifid_f[2]),
        .IDEX_Bubble(idex_b[2]), .EXMEM_Write(exmem_w[2]), .Stall_Count(sc2));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s u%0d t=%0t got=%0d expected=%0d", tag, k, $time, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; ex_rt = 0; id_usesrt = 0;
        ex_memread = 0; br = 0; jp = 0; busy = 0;
    endtask

    // Compare this cycle's outputs against the model, then advance the model one clock.
    task automatic step();
        bit hz, e_pc, e_ifw, e_fl, e_bub, e_exm;
        logic [31:0] obs_sc;
        @(negedge CLK);
        hz = ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (id_usesrt && (ex_rt == id_rt)));
        for (int k = 0; k < 3; k++) begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_exm = 1;
            if (rst) begin
                e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
                m_ld[k] = 0; m_br[k] = 0; m_mw[k] = 0;
            end else if (m_ld[k] > 0) begin
                e_pc = 0; e_ifw = 0;
                if (busy) e_exm = 0;
                else begin e_bub = 1; m_ld[k]--; end
            end else if (m_br[k] > 0) begin
                e_fl = 1;
                if (busy) begin e_pc = 0; e_ifw = 0; e_exm = 0; end
                else m_br[k]--;
            end else if (m_mw[k]) begin
                if (busy) begin e_pc = 0; e_ifw = 0; e_exm = 0; end
                else m_mw[k] = 0;
            end else if (busy) begin
                e_pc = 0; e_ifw = 0; e_exm = 0; m_mw[k] = 1;
            end else if (br) begin
                e_fl = 1; e_bub = 1; m_br[k] = BRP[k] - 1;
            end else if (hz) begin
                e_pc = 0; e_ifw = 0; e_bub = 1; m_ld[k] = LL[k] - 1;
            end else if (jp) begin
                e_fl = 1;
            end
            obs_sc = (k == 0) ? {16'd0, sc0} : (k == 1) ? {16'd0, sc1} : {28'd0, sc2};
            chk("PC_Write",    k, {31'd0, pc_w[k]},    {31'd0, e_pc});
            chk("IFID_Write",  k, {31'd0, ifid_w[k]},  {31'd0, e_ifw});
            chk("IFID_Flush",  k, {31'd0, ifid_f[k]},  {31'd0, e_fl});
            chk("IDEX_Bubble", k, {31'd0, idex_b[k]},  {31'd0, e_bub});
            chk("EXMEM_Write", k, {31'd0, exmem_w[k]}, {31'd0, e_exm});
            chk("Stall_Count", k, obs_sc, m_sc[k]);
            if (rst) m_sc[k] = 0;
            else if (!e_pc && m_sc[k] < MAXC[k]) m_sc[k]++;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin m_ld[k] = 0; m_br[k] = 0; m_sc[k] = 0; m_mw[k] = 0; end
        idle();
        rst = 1;
        @(posedge CLK);
        #1;
        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rst = 1; id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
            id_usesrt = 1'($urandom); ex_memread = 1'($urandom); br = 1'($urandom);
            jp = 1'($urandom); busy = 1'($urandom);
            step();
        end
        idle(); step();
        // load-use on rs, then same with r0 destination
        ex_memread = 1; ex_rt = 5; id_rs = 5; step();
        idle(); repeat (4) step();
        ex_memread = 1; ex_rt = 0; id_rs = 0; step();
        idle(); step();
        // load-use via rt
        ex_memread = 1; ex_rt = 9; id_rt = 9; id_usesrt = 1; step();
        idle(); repeat (3) step();
        // branch and hazard together
        br = 1; ex_memread = 1; ex_rt = 7; id_rs = 7; step();
        idle(); repeat (4) step();
        // jump
        jp = 1; step();
        idle(); step();
        // hazard, then 4 busy cycles inside the load stall
        ex_memread = 1; ex_rt = 3; id_rs = 3; step();
        idle(); busy = 1; repeat (4) step();
        idle(); repeat (4) step();
        // busy during branch flush
        br = 1; step();
        idle(); busy = 1; repeat (2) step();
        idle(); repeat (4) step();
        // long freeze to saturate the narrow counter
        busy = 1; repeat (20) step();
        idle(); repeat (2) step();
        // reset in the middle of a stall
        ex_memread = 1; ex_rt = 4; id_rs = 4; step();
        idle(); rst = 1; step();
        idle(); repeat (3) step();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            busy       = ($urandom_range(0, 5) == 0);
            br         = ($urandom_range(0, 7) == 0);
            jp         = ($urandom_range(0, 7) == 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            id_usesrt  = 1'($urandom);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rt      = 5'($urandom_range(0, 3));
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write-enable and flush/bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, taken branches, jumps and data-memory wait states, and holds the pipeline in the required state for the required number of cycles. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..7)
BR_PENALTY, 1, cycles of IF/ID flush after a taken branch (1..7)
CNT_W, 16, width of Stall_Count

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt as a source
EX_MemRead  in  1  instruction in EX is a load
EX_Rt  in  5  destination register of load in EX
Branch_Taken  in  1  branch resolved taken in EX this cycle
JtoPC  in  1  jump decoded in ID this cycle
Mem_Busy  in  1  data memory not ready; MEM stage must hold
PC_Write  out  1  PC register enable
IFID_Write  out  1  IF/ID register enable
IFID_Flush  out  1  IF/ID loads NOP/zero controls
IDEX_Bubble  out  1  ID/EX loads all-zero control bits (RegWrite, MemRead, MemWrite, Branch, JtoPC, ALUOp=0)
EXMEM_Write  out  1  EX/MEM register enable
Stall_Count  out  CNT_W  total cycles with PC_Write=0, saturating

Behaviour:
- States: RUN, MEM_WAIT, LD_STALL, BR_FLUSH. A 3-bit cycle counter cnt is used by LD_STALL and BR_FLUSH.
- Outputs are combinational from state and inputs. State, cnt and Stall_Count are registered.
- Reset: in any cycle with RST=1, outputs are forced to PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Write=1. Next state is RUN, cnt=0, Stall_Count=0. Reset mid-stall or mid-flush abandons the sequence with no residual effect.
- hazard_lu = EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))).
- Default outputs (no event): PC_Write=IFID_Write=EXMEM_Write=1, IFID_Flush=IDEX_Bubble=0.
- RUN conditions, in priority order; only the highest applies:
  1. Mem_Busy: PC_Write=IFID_Write=EXMEM_Write=0, no flush/bubble. Next state MEM_WAIT.
  2. Branch_Taken: PC_Write=1 (target load), IFID_Flush=1, IDEX_Bubble=1. If BR_PENALTY>1, next state BR_FLUSH with cnt=BR_PENALTY-1; else stay in RUN.
  3. hazard_lu: PC_Write=0, IFID_Write=0, IDEX_Bubble=1. If LOAD_LAT>1, next state LD_STALL with cnt=LOAD_LAT-1; else stay in RUN.
  4. JtoPC: IFID_Flush=1 only, for 1 cycle. Stay in RUN.
- MEM_WAIT:
  - Mem_Busy=1: hold the same frozen outputs as RUN condition 1.
  - Mem_Busy=0: default outputs this cycle; next state RUN.
  - Branch_Taken and hazard_lu are ignored while frozen; the EX contents are unchanged and re-evaluated in RUN.
- LD_STALL: outputs as RUN condition 3; cnt decrements each cycle; next state RUN when cnt==1. Mem_Busy=1 in this state overrides the outputs (full freeze) and holds cnt.
- BR_FLUSH: PC_Write=1, IFID_Flush=1, IDEX_Bubble=0; cnt decrements each cycle; next state RUN when cnt==1. Mem_Busy=1 here freezes all enables and holds cnt; IFID_Flush stays 1.
- Stall_Count increments on every non-reset cycle with PC_Write=0 and holds at 2^CNT_W-1.

Test Plan:
- RST=1 for 2 cycles with random inputs -> PC_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Write=1 each cycle; after release Stall_Count=0 and state RUN (default outputs).
- EX_MemRead=1, EX_Rt=5, ID_Rs=5, LOAD_LAT=1 -> exactly 1 cycle PC_Write=0, IFID_Write=0, IDEX_Bubble=1; Stall_Count=1. Repeat with EX_Rt=0 -> no stall.
- LOAD_LAT=3, hazard_lu on cycle N -> PC_Write=0 on cycles N..N+2, default outputs on N+3; Stall_Count=3.
- Branch_Taken and hazard_lu in the same cycle, BR_PENALTY=2 -> branch wins: PC_Write=1, IFID_Flush=1, IDEX_Bubble=1 on N; IFID_Flush=1 only on N+1; no load stall.
- Mem_Busy high for 4 cycles during LD_STALL with cnt=2 -> all enables 0 for 4 cycles, then 2 more load-stall cycles; Stall_Count increases by 6.
- CNT_W=4 with 20 consecutive Mem_Busy cycles -> Stall_Count saturates at 15 and holds.
